// File: rtl/fp_pkg.sv
// Shared FPU package: sequencer state encoding, default tick widths and field widths.
package fp_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TMR_W   = 4;
  localparam int unsigned PH_W    = 4;
  localparam int unsigned LP_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd2;
  localparam logic [STATE_W-1:0] ST_S1    = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd4;
  localparam logic [STATE_W-1:0] ST_S2    = 3'd5;
  localparam logic [STATE_W-1:0] ST_KC    = 3'd6;
  localparam logic [STATE_W-1:0] ST_GOT   = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    HOLD  = ST_HOLD,
    S1    = ST_S1,
    GAP   = ST_GAP,
    S2    = ST_S2,
    KC    = ST_KC,
    GOT   = ST_GOT
  } fpsq_state_e;

  localparam int unsigned START_TICKS_DEF  = 2;
  localparam int unsigned STROB1_TICKS_DEF = 3;
  localparam int unsigned GAP_TICKS_DEF    = 1;
  localparam int unsigned STROB2_TICKS_DEF = 2;
  localparam int unsigned KC_TICKS_DEF     = 4;

  localparam logic [PH_W-1:0] PH_MAX = 4'd15;

endpackage

// File: rtl/fpsq_if.sv
// CPU/datapath handshake bundle of the FPU sequencer.
interface fpsq_if;
  import fp_pkg::*;

  logic            efp;
  logic            puf;
  logic            mode;
  logic            step;
  logic            last;
  logic            loop_req;
  logic            start;
  logic            strob1;
  logic            strob2;
  logic [PH_W-1:0] ph;
  logic [LP_W-1:0] lp;
  logic            lp_ovf;
  logic            ekc;
  logic            got;
  logic            busy;

  modport master (
    output efp, puf, mode, step, last, loop_req,
    input  start, strob1, strob2, ph, lp, lp_ovf, ekc, got, busy
  );

  modport slave (
    input  efp, puf, mode, step, last, loop_req,
    output start, strob1, strob2, ph, lp, lp_ovf, ekc, got, busy
  );

endinterface

// File: rtl/fpsq_tmr.sv
// Loadable down-counter timing each sequencer state; zero_c flags expiry.
module fpsq_tmr
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero_c
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/fpsq.sv
// FPU operation sequencer: start, two datapath strobes with loop control, completion and CPU handshake.
module fpsq
  import fp_pkg::*;
#(
  parameter int unsigned START_TICKS  = START_TICKS_DEF,
  parameter int unsigned STROB1_TICKS = STROB1_TICKS_DEF,
  parameter int unsigned GAP_TICKS    = GAP_TICKS_DEF,
  parameter int unsigned STROB2_TICKS = STROB2_TICKS_DEF,
  parameter int unsigned KC_TICKS     = KC_TICKS_DEF
) (
  input logic   __clk,
  input logic   reset,
  fpsq_if.slave bus
);

  // Timer holds N-1 on entry so a state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] T_START = TMR_W'(START_TICKS - 1);
  localparam logic [TMR_W-1:0] T_S1    = TMR_W'(STROB1_TICKS - 1);
  localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0] T_S2    = TMR_W'(STROB2_TICKS - 1);
  localparam logic [TMR_W-1:0] T_KC    = TMR_W'(KC_TICKS - 1);

  fpsq_state_e     state_q, state_nx;
  logic [PH_W-1:0] ph_q, ph_nx;
  logic [LP_W-1:0] lp_q, lp_nx;
  logic            lp_ovf_q, lp_ovf_nx;
  logic            start_q, strob1_q, strob2_q, ekc_q, got_q, busy_q;
  logic            tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic            tmr_zero_c;
  logic            go_run;

  fpsq_tmr u_tmr (
    .clk      (__clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge __clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      lp_q     <= '0;
      lp_ovf_q <= 1'b0;
      start_q  <= 1'b0;
      strob1_q <= 1'b0;
      strob2_q <= 1'b0;
      ekc_q    <= 1'b0;
      got_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      ph_q     <= ph_nx;
      lp_q     <= lp_nx;
      lp_ovf_q <= lp_ovf_nx;
      // Decoded from the next state so outputs track the state register.
      start_q  <= (state_nx == START);
      strob1_q <= (state_nx == S1);
      strob2_q <= (state_nx == S2);
      ekc_q    <= (state_nx == KC);
      got_q    <= (state_nx == GOT);
      busy_q   <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx  = state_q;
    ph_nx     = ph_q;
    lp_nx     = lp_q;
    lp_ovf_nx = lp_ovf_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    go_run    = 1'b0;

    if (state_q != IDLE && bus.puf) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.efp && !bus.puf) begin
          state_nx  = START;
          tmr_load  = 1'b1;
          tmr_val   = T_START;
          ph_nx     = '0;
          lp_nx     = '0;
          lp_ovf_nx = 1'b0;
        end
        START: if (tmr_zero_c) go_run = 1'b1;
        HOLD:  if (bus.step) state_nx = S1;
        S1: if (tmr_zero_c) begin
          state_nx = GAP;
          tmr_load = 1'b1;
          tmr_val  = T_GAP;
        end
        GAP: if (tmr_zero_c) begin
          state_nx = S2;
          tmr_load = 1'b1;
          tmr_val  = T_S2;
        end
        S2: if (tmr_zero_c) begin
          if (bus.last) begin
            state_nx = KC;
            tmr_load = 1'b1;
            tmr_val  = T_KC;
          end else if (bus.loop_req) begin
            lp_nx = lp_q + 1'b1;
            if (lp_q == '1) begin
              lp_ovf_nx = 1'b1;
              state_nx  = KC;
              tmr_load  = 1'b1;
              tmr_val   = T_KC;
            end else begin
              go_run = 1'b1;
            end
          end else begin
            go_run = 1'b1;
          end
        end
        KC:  if (tmr_zero_c) state_nx = GOT;
        GOT: if (!bus.efp) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
      if (go_run) state_nx = bus.mode ? HOLD : S1;
    end

    // Every S1 entry counts a phase and arms the strobe-1 timer.
    if (state_nx == S1 && state_q != S1) begin
      tmr_load = 1'b1;
      tmr_val  = T_S1;
      if (ph_q != PH_MAX) ph_nx = ph_q + 1'b1;
    end
  end

  assign bus.start  = start_q;
  assign bus.strob1 = strob1_q;
  assign bus.strob2 = strob2_q;
  assign bus.ekc    = ekc_q;
  assign bus.got    = got_q;
  assign bus.busy   = busy_q;
  assign bus.ph     = ph_q;
  assign bus.lp     = lp_q;
  assign bus.lp_ovf = lp_ovf_q;

endmodule

// File: tb/tb_fpsq.sv
// Directed bench for fpsq: cycle-exact vector table plus loop, step, abort and reset sequences.
module tb_fpsq;
  import fp_pkg::*;

  localparam int SEL_START  = 0;
  localparam int SEL_STROB1 = 1;
  localparam int SEL_STROB2 = 2;
  localparam int SEL_EKC    = 3;
  localparam int SEL_GOT    = 4;

  logic clk = 1'b0;
  logic reset;

  fpsq_if bus();

  fpsq dut (
    .__clk (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        efp;
    logic        last;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // {start, strob1, strob2, ekc, got, busy, ph, lp, lp_ovf}
  function automatic logic [12:0] obs();
    return {bus.start, bus.strob1, bus.strob2, bus.ekc, bus.got, bus.busy,
            bus.ph, bus.lp, bus.lp_ovf};
  endfunction

  function automatic logic [12:0] ex(input logic st, input logic s1, input logic s2,
                                     input logic k, input logic g, input logic b,
                                     input int ph, input int lp, input logic ov);
    return {st, s1, s2, k, g, b, 4'(ph), 2'(lp), ov};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      SEL_START:  return bus.start;
      SEL_STROB1: return bus.strob1;
      SEL_STROB2: return bus.strob2;
      SEL_EKC:    return bus.ekc;
      default:    return bus.got;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input logic val, input int budget,
                          input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sig(sel) === val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: timeout after %0d cycles, signal never reached %0b", name, budget, val);
    end
  endtask

  // Returns at the sample just after the n-th strob2 falling edge.
  task automatic wait_s2_ends(input int n, input int budget, input string name, output bit ok);
    logic prev;
    int   cnt;
    ok   = 1'b0;
    cnt  = 0;
    prev = bus.strob2;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (prev && !bus.strob2) cnt++;
      prev = bus.strob2;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: timeout, saw %0d of %0d strob2 ends", name, cnt, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   ok;
    logic quiet;

    reset        = 1'b1;
    bus.efp      = 1'b0;
    bus.puf      = 1'b0;
    bus.mode     = 1'b0;
    bus.step     = 1'b0;
    bus.last     = 1'b0;
    bus.loop_req = 1'b0;

    repeat (3) tick();
    check("reset_state", 16'(obs()), 16'h0);
    @(negedge clk) reset = 1'b0;

    // Basic operation: defaults, mode=0, last=1 at the first S2.
    tbl[0]  = '{1'b1, 1'b1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, ex(0, 1, 0, 0, 0, 1, 1, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, ex(0, 1, 0, 0, 0, 1, 1, 0, 0)};
    tbl[4]  = '{1'b1, 1'b1, ex(0, 1, 0, 0, 0, 1, 1, 0, 0)};
    tbl[5]  = '{1'b1, 1'b1, ex(0, 0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[6]  = '{1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[7]  = '{1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{1'b1, 1'b1, ex(0, 0, 0, 1, 0, 1, 1, 0, 0)};
    tbl[9]  = '{1'b1, 1'b1, ex(0, 0, 0, 1, 0, 1, 1, 0, 0)};
    tbl[10] = '{1'b1, 1'b1, ex(0, 0, 0, 1, 0, 1, 1, 0, 0)};
    tbl[11] = '{1'b1, 1'b1, ex(0, 0, 0, 1, 0, 1, 1, 0, 0)};
    tbl[12] = '{1'b1, 1'b1, ex(0, 0, 0, 0, 1, 1, 1, 0, 0)};
    tbl[13] = '{1'b1, 1'b1, ex(0, 0, 0, 0, 1, 1, 1, 0, 0)};
    tbl[14] = '{1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[15] = '{1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1, 0, 0)};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.efp  = tbl[i].efp;
      bus.last = tbl[i].last;
      tick();
      check($sformatf("basic_row%0d", i), 16'(obs()), 16'(tbl[i].exp));
    end

    // Three loop-backs then last.
    @(negedge clk);
    bus.efp = 1'b1; bus.last = 1'b0; bus.loop_req = 1'b1;
    wait_s2_ends(3, 200, "loop3_s2_ends", ok);
    @(negedge clk) bus.last = 1'b1;
    wait_for(SEL_GOT, 1'b1, 100, "loop3_got", ok);
    check("loop3_ph", 16'(bus.ph), 16'd4);
    check("loop3_lp", 16'(bus.lp), 16'd3);
    check("loop3_ovf", 16'(bus.lp_ovf), 16'd0);
    @(negedge clk);
    bus.efp = 1'b0; bus.last = 1'b0; bus.loop_req = 1'b0;
    tick();
    check("loop3_idle", 16'(bus.busy), 16'd0);

    // Four loop-backs wrap lp and end the operation.
    @(negedge clk);
    bus.efp = 1'b1; bus.last = 1'b0; bus.loop_req = 1'b1;
    wait_s2_ends(3, 200, "wrap_s2_ends3", ok);
    check("wrap_3rd_back_to_s1", 16'({bus.strob1, bus.ekc, bus.lp}), 16'({1'b1, 1'b0, 2'd3}));
    wait_s2_ends(1, 100, "wrap_s2_end4", ok);
    check("wrap_kc_entry", 16'(obs()), 16'(ex(0, 0, 0, 1, 0, 1, 4, 0, 1)));
    wait_for(SEL_GOT, 1'b1, 100, "wrap_got", ok);
    @(negedge clk);
    bus.efp = 1'b0; bus.loop_req = 1'b0;
    tick();

    // Step mode: idle in HOLD, strobe follows the step pulse by one cycle.
    @(negedge clk);
    bus.mode = 1'b1; bus.last = 1'b1; bus.efp = 1'b1;
    wait_for(SEL_START, 1'b1, 20, "step_start_hi", ok);
    wait_for(SEL_START, 1'b0, 20, "step_start_lo", ok);
    quiet = 1'b0;
    for (int i = 0; i < 10; i++) begin
      quiet = quiet | bus.strob1 | bus.strob2 | bus.ekc | !bus.busy;
      tick();
    end
    check("hold_quiet", 16'(quiet), 16'd0);
    @(negedge clk) bus.step = 1'b1;
    tick();
    check("step_to_strob1", 16'({bus.strob1, bus.ph}), 16'({1'b1, 4'd1}));
    @(negedge clk) bus.step = 1'b0;
    wait_for(SEL_GOT, 1'b1, 100, "step_got", ok);
    @(negedge clk);
    bus.efp = 1'b0; bus.mode = 1'b0;
    tick();

    // Abort in the 2nd strob1 cycle, then efp+puf together in IDLE.
    @(negedge clk) bus.efp = 1'b1;
    wait_for(SEL_STROB1, 1'b1, 20, "abort_s1", ok);
    tick();
    check("abort_s1_2nd", 16'(bus.strob1), 16'd1);
    @(negedge clk) bus.puf = 1'b1;
    tick();
    check("abort_idle", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 1, 0, 0)));
    quiet = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      quiet = quiet | bus.got | bus.busy | bus.start;
    end
    check("abort_efp_puf_idle", 16'(quiet), 16'd0);
    @(negedge clk);
    bus.puf = 1'b0; bus.efp = 1'b0;
    tick();

    // Reset in KC, then a clean operation.
    @(negedge clk) bus.efp = 1'b1;
    wait_for(SEL_EKC, 1'b1, 50, "rst_kc", ok);
    #2 reset = 1'b1;
    bus.efp = 1'b0;
    #1 check("rst_async", 16'(obs()), 16'h0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) bus.efp = 1'b1;
    tick();
    check("rst_restart", 16'(obs()), 16'(ex(1, 0, 0, 0, 0, 1, 0, 0, 0)));
    wait_for(SEL_GOT, 1'b1, 50, "rst_got", ok);
    check("rst_clean_op", 16'({bus.ph, bus.lp, bus.lp_ovf}), 16'({4'd1, 2'd0, 1'b0}));
    @(negedge clk) bus.efp = 1'b0;
    tick();
    check("final_idle", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 1, 0, 0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpsq.md
FPSQ -- requirements
Module: fpsq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  START_TICKS  2  start pulse width, cycles
  STROB1_TICKS  3  strob1 width, cycles
  GAP_TICKS  1  strob1-to-strob2 gap, cycles
  STROB2_TICKS  2  strob2 width, cycles
  KC_TICKS  4  completion pulse width, cycles
  All parameters are 1..15.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  __clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  efp  in  1  FPU operation request (level) from CPU
  puf  in  1  abort (level)
  mode  in  1  step mode enable
  step  in  1  single-cycle step pulse
  last  in  1  datapath: current phase is final
  loop_req  in  1  datapath: repeat phase (normalize/shift loop)
  start  out  1  operation start pulse
  strob1  out  1  datapath strobe 1
  strob2  out  1  datapath strobe 2
  ph  out  4  phase count of the current operation
  lp  out  2  loop counter
  lp_ovf  out  1  loop counter wrapped
  ekc  out  1  completion pulse
  got  out  1  handshake acknowledge to CPU
  busy  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL have the states IDLE, START, HOLD, S1, GAP, S2, KC and GOT, with one shared down-counter timing each state.
REQ-004 In IDLE, efp=1 and puf=0 SHALL cause entry to START on the next cycle, and lp, ph and lp_ovf SHALL clear on that same edge.
REQ-005 START SHALL drive start=1 for exactly START_TICKS cycles and then go to HOLD if mode=1, otherwise to S1.
REQ-006 HOLD SHALL wait with all strobes low until step=1 and then enter S1 on the next cycle; a step pulse seen in any other state SHALL be ignored.
REQ-007 Every entry to S1 SHALL increment ph, saturating at 15.
REQ-008 S1 SHALL drive strob1=1 for exactly STROB1_TICKS cycles and then go to GAP.
REQ-009 GAP SHALL last GAP_TICKS cycles with no strobe asserted, then go to S2.
REQ-010 S2 SHALL drive strob2=1 for STROB2_TICKS cycles, and last and loop_req SHALL be sampled only in the final S2 cycle.
REQ-011 At the end of S2:
  - last=1 SHALL go to KC; last has priority over loop_req.
  - last=0 and loop_req=1 SHALL increment lp; if lp was 3, lp wraps to 0, lp_ovf is set and the FSM goes to KC; otherwise it goes to HOLD (mode=1) or S1 (mode=0).
  - last=0 and loop_req=0 SHALL go to HOLD or S1 without changing lp.
REQ-012 KC SHALL drive ekc=1 for exactly KC_TICKS cycles and then go to GOT.
REQ-013 GOT SHALL hold got=1 until efp=0 and then return to IDLE; a new request is accepted only after efp has been seen low.
REQ-014 puf=1 in any non-IDLE state SHALL force IDLE on the next edge, with start, strob1, strob2, ekc and got low and got never asserted for the aborted operation; ph, lp and lp_ovf SHALL hold their values.
REQ-015 efp=1 together with puf=1 in IDLE SHALL leave the FSM in IDLE.
REQ-016 strob1 and strob2 SHALL never be high in the same cycle.
REQ-017 All outputs SHALL be registered; an output change SHALL appear in the cycle after the state transition edge.
REQ-018 A change of mode while busy SHALL take effect only at the next S1 entry decision.

Reset
REQ-019 reset=1 SHALL asynchronously force IDLE, with start, strob1, strob2, ekc, got, busy and lp_ovf at 0, ph=0, lp=0 and the down-counter at 0.
REQ-020 Reset asserted mid-operation SHALL abort without a got or ekc pulse, and the first edge after reset release SHALL evaluate IDLE.

Structure
REQ-021 The state encoding localparams and the default tick constants SHALL live in the shared FPU package fp_pkg.
REQ-022 The tick timer SHALL be one sub-module, fpsq_tmr, a loadable 4-bit down-counter with a zero flag.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Defaults, mode=0, efp=1, last=1 at first S2 -> start 2 cycles, strob1 3, gap 1, strob2 2, ekc 4, got held until efp=0; ph=1, lp=0.
  - last=0 with loop_req=1 for three S2 ends, then last=1 -> ph=4, lp=3, lp_ovf=0.
  - loop_req=1 with last=0 for four S2 ends -> lp wraps to 0, lp_ovf=1, KC entered after the 4th S2.
  - mode=1, step pulsed after 10 idle cycles in HOLD -> strob1 rises exactly 1 cycle after step; no strobes before step.
  - puf=1 during the 2nd strob1 cycle -> busy=0 and strob1=0 next cycle, got never asserted.
  - reset pulsed during KC -> ekc=0 immediately, all outputs at reset values; a following efp starts a clean operation with ph=1.
